phv_merge: RTL and testbench

- Downstream neighbour of the per-container ALU lanes in each RMT stage.
- Captures the stage's input PHV when the action set is issued, buffers it while the ALUs compute, and collects each lane's container_out/container_out_valid.
- Merges the results into the buffered PHV and presents the updated PHV to the next stage over a valid/ready handshake.

---
 rtl/phv_merge_pkg.sv | 25 ++
 rtl/phv_sync_fifo.sv | 51 +++++
 rtl/phv_merge.sv | 183 ++++++++++++++++++
 tb/tb_phv_merge.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/phv_merge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : phv_merge_pkg                                                   |
// | Brief    : Shared container/PHV geometry for the RMT stage blocks.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package phv_merge_pkg;

  // Default stage geometry: eight 32-bit containers under 256 metadata bits
  localparam int c_container_w = 32;
  localparam int c_num_alu     = 8;
  localparam int c_meta_w      = 256;

  // Total PHV width: containers in the low bits, metadata on top
  function automatic int phv_len(input int num_alu, input int data_w, input int meta_w);
    return num_alu * data_w + meta_w;
  endfunction

  // LSB position of container 'lane' inside the PHV
  function automatic int lane_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phv_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : phv_sync_fifo                                                   |
// | Brief    : First-word-fall-through synchronous FIFO with wrap-bit pointers.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module phv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;

  // Storage write; the caller never pushes into a full FIFO unless it also pops
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[c_aw-1:0]] <= din;
  end

  // Pointer advance; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign dout  = r_mem[r_rd_ptr[c_aw-1:0]];
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                 (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign count = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/phv_merge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : phv_merge                                                       |
// | Brief    : Buffers the stage PHV while the ALU lanes compute, then merges  |
// |            lane results into it and hands it downstream (valid/ready).     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module phv_merge
  import phv_merge_pkg::*;
#(
  parameter int NUM_ALU    = c_num_alu,
  parameter int DATA_WIDTH = c_container_w,
  parameter int META_WIDTH = c_meta_w,
  parameter int PHV_LEN    = phv_len(NUM_ALU, DATA_WIDTH, META_WIDTH),
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PHV_LEN-1:0]            phv_in,
  input  logic                          phv_in_valid,
  input  logic [NUM_ALU-1:0]            lane_mask_in,
  output logic                          phv_in_ready,
  input  logic [NUM_ALU*DATA_WIDTH-1:0] alu_container_in,
  input  logic [NUM_ALU-1:0]            alu_container_valid,
  output logic [PHV_LEN-1:0]            phv_out,
  output logic                          phv_out_valid,
  input  logic                          phv_out_ready,
  output logic                          err_overflow,
  output logic                          err_unexpected
);

  localparam int              c_cw    = $clog2(DEPTH) + 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

  logic [NUM_ALU+PHV_LEN-1:0]            w_phv_dout;
  logic [NUM_ALU-1:0]                    w_head_mask;
  logic [PHV_LEN-1:0]                    w_head_phv;
  logic                                  w_phv_full;
  logic                                  w_phv_empty;
  logic [c_cw-1:0]                       w_phv_count;
  logic                                  w_phv_push;
  logic                                  w_phv_drop;
  logic [NUM_ALU-1:0][DATA_WIDTH-1:0]    w_lane_dout;
  logic [NUM_ALU-1:0]                    w_lane_full;
  logic [NUM_ALU-1:0]                    w_lane_empty;
  logic [NUM_ALU-1:0][c_cw-1:0]          w_lane_count;
  logic [NUM_ALU-1:0]                    w_lane_push;
  logic [NUM_ALU-1:0]                    w_lane_pop;
  logic [NUM_ALU-1:0]                    w_lane_ovf;
  logic [NUM_ALU-1:0]                    w_lane_unx;
  logic                                  w_merge_ok;
  logic                                  w_load;
  logic [PHV_LEN-1:0]                    w_merged;

  logic [NUM_ALU-1:0][c_cw-1:0]          r_pend;
  logic [PHV_LEN-1:0]                    r_phv_out;
  logic                                  r_phv_out_valid;
  logic                                  r_err_ovf;
  logic                                  r_err_unx;
  logic                                  r_rdy_en;

  assign w_head_mask = w_phv_dout[PHV_LEN +: NUM_ALU];
  assign w_head_phv  = w_phv_dout[PHV_LEN-1:0];

  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign phv_in_ready = r_rdy_en && (!w_phv_full || w_load);
  assign w_phv_push   = phv_in_valid && phv_in_ready;
  assign w_phv_drop   = phv_in_valid && r_rdy_en && (w_phv_count == c_depth) && !w_load;

  phv_sync_fifo #(
    .WIDTH (NUM_ALU + PHV_LEN),
    .DEPTH (DEPTH)
  ) u_phv_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_phv_push),
    .pop   (w_load),
    .din   ({lane_mask_in, phv_in}),
    .dout  (w_phv_dout),
    .full  (w_phv_full),
    .empty (w_phv_empty),
    .count (w_phv_count)
  );

  generate
    for (genvar g = 0; g < NUM_ALU; g++) begin : g_lane
      phv_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
      ) u_lane_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_lane_push[g]),
        .pop   (w_lane_pop[g]),
        .din   (alu_container_in[g*DATA_WIDTH +: DATA_WIDTH]),
        .dout  (w_lane_dout[g]),
        .full  (w_lane_full[g]),
        .empty (w_lane_empty[g]),
        .count (w_lane_count[g])
      );
    end
  endgenerate

  // Accept a lane result only if a buffered PHV still waits for it on that lane
  always_comb begin
    w_lane_push = '0;
    w_lane_ovf  = '0;
    w_lane_unx  = '0;
    for (int i = 0; i < NUM_ALU; i++) begin
      if (alu_container_valid[i]) begin
        if (w_lane_full[i] && !w_lane_pop[i])       w_lane_ovf[i]  = 1'b1;
        else if (w_lane_count[i] == r_pend[i])      w_lane_unx[i]  = 1'b1;
        else                                        w_lane_push[i] = 1'b1;
      end
    end
  end

  // Head PHV is complete once every masked lane has a result waiting
  always_comb begin
    w_merge_ok = !w_phv_empty;
    for (int i = 0; i < NUM_ALU; i++) begin
      if (w_head_mask[i] && w_lane_empty[i]) w_merge_ok = 1'b0;
    end
  end

  assign w_load     = w_merge_ok && (!r_phv_out_valid || phv_out_ready);
  assign w_lane_pop = {NUM_ALU{w_load}} & w_head_mask;

  // Substitute masked containers; unmasked containers and metadata pass through
  always_comb begin
    w_merged = w_head_phv;
    for (int i = 0; i < NUM_ALU; i++) begin
      if (w_head_mask[i]) w_merged[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = w_lane_dout[i];
    end
  end

  // Per-lane count of buffered PHVs whose mask bit is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NUM_ALU; i++) begin
        if (w_phv_push && lane_mask_in[i] && !w_lane_pop[i])
          r_pend[i] <= r_pend[i] + 1'b1;
        else if (!(w_phv_push && lane_mask_in[i]) && w_lane_pop[i])
          r_pend[i] <= r_pend[i] - 1'b1;
      end
    end
  end

  // Output register: load a merged PHV, or retire it once accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phv_out       <= '0;
      r_phv_out_valid <= 1'b0;
    end else if (w_load) begin
      r_phv_out       <= w_merged;
      r_phv_out_valid <= 1'b1;
    end else if (phv_out_ready) begin
      r_phv_out_valid <= 1'b0;
    end
  end

  // Sticky error flags, plus input-ready enable one cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovf <= 1'b0;
      r_err_unx <= 1'b0;
      r_rdy_en  <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_phv_drop || (|w_lane_ovf)) r_err_ovf <= 1'b1;
      if (|w_lane_unx)                 r_err_unx <= 1'b1;
    end
  end

  assign phv_out        = r_phv_out;
  assign phv_out_valid  = r_phv_out_valid;
  assign err_overflow   = r_err_ovf;
  assign err_unexpected = r_err_unx;

endmodule
`default_nettype wire

// File: tb/tb_phv_merge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_phv_merge                                                    |
// | Brief    : Directed table-driven bench for phv_merge.                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_phv_merge;

  localparam int PHV_LEN = 512;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PHV_LEN-1:0] phv_in = '0;
  logic               phv_in_valid = 1'b0;
  logic [7:0]         lane_mask_in = '0;
  logic               phv_in_ready;
  logic [255:0]       alu_container_in = '0;
  logic [7:0]         alu_container_valid = '0;
  logic [PHV_LEN-1:0] phv_out;
  logic               phv_out_valid;
  logic               phv_out_ready = 1'b1;
  logic               err_overflow;
  logic               err_unexpected;

  int n_vec = 0;
  int n_bad = 0;

  phv_merge #(
    .NUM_ALU    (8),
    .DATA_WIDTH (32),
    .META_WIDTH (256),
    .PHV_LEN    (PHV_LEN),
    .DEPTH      (4)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .phv_in              (phv_in),
    .phv_in_valid        (phv_in_valid),
    .lane_mask_in        (lane_mask_in),
    .phv_in_ready        (phv_in_ready),
    .alu_container_in    (alu_container_in),
    .alu_container_valid (alu_container_valid),
    .phv_out             (phv_out),
    .phv_out_valid       (phv_out_valid),
    .phv_out_ready       (phv_out_ready),
    .err_overflow        (err_overflow),
    .err_unexpected      (err_unexpected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]        mask;
    logic [31:0]       base;
    logic [31:0]       meta;
    logic [7:0][31:0]  res;
    int                dly;   // edge (after push edge) at which lanes 0..6 strobe
    int                dly7;  // edge at which lane 7 strobes
    int                lat;   // expected edge of phv_out_valid after push edge
  } vec_t;

  vec_t tbl [7];

  // Container i = base + i*0x10, metadata words = meta ^ j
  function automatic logic [PHV_LEN-1:0] mk_phv(input logic [31:0] base, input logic [31:0] meta);
    logic [PHV_LEN-1:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = base + 32'(i) * 32'h10;
    for (int j = 0; j < 8; j++) p[256 + j*32 +: 32] = meta ^ 32'(j);
    return p;
  endfunction

  function automatic logic [PHV_LEN-1:0] merge_exp(input logic [PHV_LEN-1:0] p,
                                                   input logic [7:0] mask,
                                                   input logic [7:0][31:0] res);
    logic [PHV_LEN-1:0] q;
    q = p;
    for (int i = 0; i < 8; i++) if (mask[i]) q[i*32 +: 32] = res[i];
    return q;
  endfunction

  task automatic chk_phv(input string nm, input logic [PHV_LEN-1:0] got, input logic [PHV_LEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Push one PHV, strobe its lane results, and time the merged output
  task automatic apply(input vec_t v, output int lat, output logic [PHV_LEN-1:0] got);
    lat = -1;
    got = '0;
    @(negedge clk);
    phv_in       = mk_phv(v.base, v.meta);
    lane_mask_in = v.mask;
    phv_in_valid = 1'b1;
    @(negedge clk);
    phv_in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (lat < 0) begin
        alu_container_in    = v.res;
        alu_container_valid = ((k == v.dly)  ? (v.mask & 8'h7F) : 8'h00) |
                              ((k == v.dly7) ? (v.mask & 8'h80) : 8'h00);
        @(posedge clk);
        #1;
        if (phv_out_valid) begin
          lat = k;
          got = phv_out;
        end
        @(negedge clk);
        alu_container_valid = '0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int                 lat;
    logic [PHV_LEN-1:0] got;
    logic [PHV_LEN-1:0] held;
    logic [7:0][31:0]   res_a [4];
    logic [PHV_LEN-1:0] exp_a [4];
    vec_t               v;

    // ---------------- vector table ----------------
    for (int t = 0; t < 7; t++)
      for (int i = 0; i < 8; i++) tbl[t].res[i] = 32'h1000 * 32'(t + 1) + 32'(i);
    tbl[0].mask = 8'h05; tbl[0].base = 32'h0;   tbl[0].meta = 32'hA5A5_0000;
    tbl[0].res[0] = 32'h1234; tbl[0].res[2] = 32'hBEEF;
    tbl[0].dly = 3; tbl[0].dly7 = 3; tbl[0].lat = 4;
    tbl[1].mask = 8'h00; tbl[1].base = 32'h100; tbl[1].meta = 32'h1111_0000;
    tbl[1].dly = 1; tbl[1].dly7 = 1; tbl[1].lat = 1;
    tbl[2].mask = 8'hFF; tbl[2].base = 32'h200; tbl[2].meta = 32'h2222_0000;
    tbl[2].dly = 2; tbl[2].dly7 = 2; tbl[2].lat = 3;
    tbl[3].mask = 8'h80; tbl[3].base = 32'h300; tbl[3].meta = 32'h3333_0000;
    tbl[3].dly = 5; tbl[3].dly7 = 5; tbl[3].lat = 6;
    tbl[4].mask = 8'h01; tbl[4].base = 32'h400; tbl[4].meta = 32'h4444_0000;
    tbl[4].dly = 1; tbl[4].dly7 = 1; tbl[4].lat = 2;
    tbl[5].mask = 8'h5A; tbl[5].base = 32'h500; tbl[5].meta = 32'h5555_0000;
    tbl[5].dly = 4; tbl[5].dly7 = 4; tbl[5].lat = 5;
    // lane 7 two cycles behind the others
    tbl[6].mask = 8'hFF; tbl[6].base = 32'h600; tbl[6].meta = 32'h6666_0000;
    tbl[6].dly = 2; tbl[6].dly7 = 4; tbl[6].lat = 5;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk_bit("rst_out_valid", phv_out_valid, 1'b0);
    chk_phv("rst_out_data", phv_out, '0);
    chk_bit("rst_err_ovf", err_overflow, 1'b0);
    chk_bit("rst_err_unx", err_unexpected, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_bit("rst_in_ready", phv_in_ready, 1'b1);

    // ---------------- table vectors ----------------
    for (int t = 0; t < 7; t++) begin
      apply(tbl[t], lat, got);
      chk_int($sformatf("vec%0d_latency", t), lat, tbl[t].lat);
      chk_phv($sformatf("vec%0d_data", t), got,
              merge_exp(mk_phv(tbl[t].base, tbl[t].meta), tbl[t].mask, tbl[t].res));
    end

    // ---------------- fill PHV FIFO, overflow, drain in order ----------------
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 8; i++) res_a[n][i] = 32'hC000_0000 + 32'(n) * 32'h100 + 32'(i);
      exp_a[n] = merge_exp(mk_phv(32'h700 + 32'(n) * 32'h1000, 32'h5EED_0000 + 32'(n)), 8'hFF, res_a[n]);
    end
    @(negedge clk);
    phv_out_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      phv_in       = mk_phv(32'h700 + 32'(n) * 32'h1000, 32'h5EED_0000 + 32'(n));
      lane_mask_in = 8'hFF;
      phv_in_valid = 1'b1;
      @(negedge clk);
    end
    phv_in_valid = 1'b0;
    chk_bit("full_in_ready", phv_in_ready, 1'b0);
    chk_bit("full_no_ovf_yet", err_overflow, 1'b0);
    phv_in       = mk_phv(32'hDEAD_0000, 32'hDEAD_0000);
    phv_in_valid = 1'b1;
    @(negedge clk);
    phv_in_valid = 1'b0;
    chk_bit("full_push_ovf", err_overflow, 1'b1);
    for (int n = 0; n < 4; n++) begin
      alu_container_in    = res_a[n];
      alu_container_valid = 8'hFF;
      @(negedge clk);
    end
    alu_container_valid = '0;
    repeat (2) @(negedge clk);
    chk_bit("hold_valid", phv_out_valid, 1'b1);
    held = phv_out;
    chk_phv("hold_first", held, exp_a[0]);
    @(negedge clk);
    chk_phv("hold_stable", phv_out, held);
    phv_out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      chk_bit($sformatf("drain%0d_valid", n), phv_out_valid, 1'b1);
      chk_phv($sformatf("drain%0d_data", n), phv_out, exp_a[n]);
      @(negedge clk);
    end
    chk_bit("drain_done", phv_out_valid, 1'b0);

    // ---------------- unexpected strobe ----------------
    chk_bit("unx_before", err_unexpected, 1'b0);
    alu_container_in    = '0;
    alu_container_in[3*32 +: 32] = 32'hBAD0_0003;
    alu_container_valid = 8'h08;
    @(negedge clk);
    alu_container_valid = '0;
    chk_bit("unx_set", err_unexpected, 1'b1);
    v = tbl[4];
    v.mask = 8'h08; v.base = 32'h900; v.meta = 32'h9999_0000;
    v.res[3] = 32'h600D_0003; v.dly = 2; v.dly7 = 2;
    apply(v, lat, got);
    chk_int("unx_drop_latency", lat, 3);
    chk_phv("unx_drop_data", got, merge_exp(mk_phv(v.base, v.meta), v.mask, v.res));
    chk_bit("unx_sticky", err_unexpected, 1'b1);

    // ---------------- reset mid-operation ----------------
    phv_out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      phv_in       = mk_phv(32'hA00 + 32'(n), 32'hAAAA_0000);
      lane_mask_in = 8'h00;
      phv_in_valid = 1'b1;
      @(negedge clk);
    end
    phv_in_valid = 1'b0;
    @(negedge clk);
    chk_bit("pre_rst_valid", phv_out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("mid_rst_valid", phv_out_valid, 1'b0);
    chk_phv("mid_rst_data", phv_out, '0);
    chk_bit("mid_rst_ovf", err_overflow, 1'b0);
    chk_bit("mid_rst_unx", err_unexpected, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    phv_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_bit("post_rst_empty", phv_out_valid, 1'b0);
    v = tbl[1];
    v.base = 32'hB00; v.meta = 32'hBBBB_0000;
    apply(v, lat, got);
    chk_int("post_rst_latency", lat, 1);
    chk_phv("post_rst_data", got, mk_phv(32'hB00, 32'hBBBB_0000));
    repeat (3) @(negedge clk);
    chk_bit("post_rst_no_stale", phv_out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
